instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the main control decoder: takes a control-signal bundle plus register/immediate fields and encodes the matching 32-bit MIPS instruction word.
- Writes each encoded word sequentially into instruction memory through a write/ack port.
- Used to load test programs into imem from a control-level description. Bundles that map to no supported instruction are rejected.

Parameters:
ADDR_W, 8, width of the imem word address.
DEPTH, 256, number of loadable words; must satisfy DEPTH <= 2**ADDR_W and DEPTH >= 1.
START_ADDR, 0, first word address written after reset or clr.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
clr  input  1  synchronous clear of address counter, full flag and error counter; ignored unless state is IDLE.
in_valid  input  1  bundle valid.
in_ready  output  1  bundle accepted when in_valid & in_ready.
RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemToReg, Jump  input  1 each  control bundle.
ALUOp  input  2  control bundle.
rs, rt, rd, shamt  input  5 each  instruction fields.
funct  input  6  R-type function.
imm  input  16  I-type immediate.
target  input  26  J-type target.
imem_we  output  1  write strobe, held until ack.
imem_addr  output  ADDR_W  write address.
imem_wdata  output  32  encoded word.
imem_ack  input  1  memory accepted the write.
full  output  1  DEPTH words written.
err_illegal  output  1  one-cycle pulse on a rejected bundle.
err_count  output  8  saturating count of rejected bundles.
chk_err  output  1  see Optional Feature.

Behaviour:
- Reset (rst_n=0 at edge) has priority over everything. Outputs after reset:
  - in_ready=1, imem_we=0, imem_addr=START_ADDR, imem_wdata=0
  - full=0, err_illegal=0, err_count=0, chk_err=0, state=IDLE
- Encoding: exact match on all 9 control bits; any other combination is illegal.
  - R: RegWrite=1, RegDst=1, ALUOp=10, rest 0 -> {000000, rs, rt, rd, shamt, funct}
  - lw: RegWrite=1, ALUSrc=1, MemToReg=1, ALUOp=00, rest 0 -> {100011, rs, rt, imm}
  - sw: ALUSrc=1, MemWrite=1, ALUOp=00, rest 0 -> {101011, rs, rt, imm}
  - beq: Branch=1, ALUOp=01, rest 0 -> {000100, rs, rt, imm}
  - addi: RegWrite=1, ALUSrc=1, ALUOp=00, rest 0 -> {001000, rs, rt, imm}
  - j: Jump=1, ALUOp=00, rest 0 -> {000010, target}
  - All-zero bundle is illegal.
- State machine IDLE / WRITE / REJECT:
  - in_ready = (state==IDLE) & ~full.
  - IDLE, accept, legal: register word; WRITE next cycle, so imem_we=1 in cycle N+1 for accept in cycle N.
  - IDLE, accept, illegal: REJECT for one cycle. err_illegal=1 there, err_count+1 (saturates at 255), no write, address unchanged, then IDLE.
  - WRITE: imem_we, imem_addr and imem_wdata held stable until imem_ack=1. On the ack edge imem_we drops and the state returns to IDLE.
  - WRITE ack at address START_ADDR+DEPTH-1: full=1 and the address holds. Otherwise imem_addr increments (ADDR_W wrap).
  - imem_ack while not in WRITE is ignored.
- full stays 1 until clr in IDLE or reset. clr in IDLE: imem_addr=START_ADDR, full=0, err_count=0.
- clr and in_valid in the same IDLE cycle: clr wins and the bundle is not accepted (in_ready forced 0 that cycle).
- Reset mid-WRITE abandons the write immediately; imem_we=0 the next cycle.
- Minimum throughput: one word per 2 cycles with immediate ack.

Optional Feature:
- Macro ENC_CHECK_EN.
- When defined: the registered word's opcode is re-decoded with the standard main-decoder table and compared to the captured control bundle during WRITE.
  - A mismatch sets sticky chk_err=1.
  - chk_err is cleared only by reset or clr.
- When undefined: no check logic; chk_err tied 0.

Test Plan:
- Reset then R bundle: rs=1, rt=2, rd=3, shamt=0, funct=0x20 -> imem_we in the next cycle, addr=0, wdata=0x00221820; ack -> addr=1, in_ready=1.
- lw rs=0, rt=8, imm=0x0004 -> wdata=0x8C080004. Hold imem_ack=0 for 3 cycles -> we, addr and data stable, in_ready=0 throughout.
- Bundle with Jump=1 and Branch=1 -> err_illegal pulse one cycle, err_count=1, no imem_we, addr unchanged. All-zero bundle -> err_count=2.
- DEPTH=4: load sw, beq, addi, j (j target=0x0000010 -> 0x08000010) -> full=1 after the 4th ack, in_ready=0. clr -> addr=0, full=0.
- Assert rst_n=0 while imem_we=1 awaiting ack -> next cycle imem_we=0, addr=START_ADDR, state IDLE.
- With ENC_CHECK_EN defined: legal stream -> chk_err stays 0; with the encode table forced wrong (fault injection) -> chk_err=1 and sticky until clr.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//
// Purpose:
//   Inverse of the MIPS main control decoder. Takes a control-signal bundle
//   plus register/immediate fields, encodes the matching 32-bit instruction
//   word and writes it into instruction memory through a write/ack port.
//   Successive words go to successive addresses starting at START_ADDR.
//   Bundles that match no supported instruction are rejected and counted.
//
// Parameters:
//   ADDR_W     - width of the imem word address
//   DEPTH      - number of loadable words (1 <= DEPTH <= 2**ADDR_W)
//   START_ADDR - first word address written after reset or clr
//
// Ports:
//   clk, rst_n           - clock (rising edge), synchronous active-low reset
//   clr                  - clears address, full flag, error counter (IDLE only)
//   in_valid / in_ready  - bundle handshake
//   RegWrite .. ALUOp    - control bundle to encode
//   rs, rt, rd, shamt, funct, imm, target - instruction fields
//   imem_we/addr/wdata   - write request, held until imem_ack
//   imem_ack             - memory accepted the write
//   full                 - DEPTH words have been written
//   err_illegal          - one-cycle pulse on a rejected bundle
//   err_count            - saturating count of rejected bundles
//   chk_err              - sticky encode self-check error
//
// Optional feature (macro ENC_CHECK_EN):
//   When defined, the opcode of the word being written is re-decoded with the
//   standard main-decoder table and compared against the captured bundle;
//   a mismatch sets chk_err until reset or clr. When undefined chk_err is 0.
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              RegWrite,
    input  logic              RegDst,
    input  logic              ALUSrc,
    input  logic              Branch,
    input  logic              MemWrite,
    input  logic              MemToReg,
    input  logic              Jump,
    input  logic [1:0]        ALUOp,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              full,
    output logic              err_illegal,
    output logic [7:0]        err_count,
    output logic              chk_err
);

    // Control bundle packed as {RegWrite, RegDst, ALUSrc, Branch, MemWrite,
    // MemToReg, Jump, ALUOp[1:0]}.
    localparam logic [8:0] CTRL_R    = 9'b1_1_0_0_0_0_0_10;
    localparam logic [8:0] CTRL_LW   = 9'b1_0_1_0_0_1_0_00;
    localparam logic [8:0] CTRL_SW   = 9'b0_0_1_0_1_0_0_00;
    localparam logic [8:0] CTRL_BEQ  = 9'b0_0_0_1_0_0_0_01;
    localparam logic [8:0] CTRL_ADDI = 9'b1_0_1_0_0_0_0_00;
    localparam logic [8:0] CTRL_J    = 9'b0_0_0_0_0_0_1_00;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
    // Last loadable address; arithmetic wraps at ADDR_W like the counter.
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(START_ADDR + DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        REJECT = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_full;
    logic              r_err_illegal;
    logic [7:0]        r_err_count;

    logic [8:0]        w_ctrl;
    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_in_ready;

    assign w_ctrl = {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemToReg, Jump, ALUOp};

    // clr owns the IDLE cycle it appears in, so a coincident bundle is refused.
    assign w_in_ready = (r_state == IDLE) && !r_full && !clr;

    // Encoder: exact match on all nine control bits.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a value unassigned and a latch is inferred.
    always_comb begin
        w_legal = 1'b1;
        w_word  = '0;
        case (w_ctrl)
            CTRL_R:    w_word = {OP_R, rs, rt, rd, shamt, funct};
            CTRL_LW:   w_word = {OP_LW, rs, rt, imm};
            CTRL_SW:   w_word = {OP_SW, rs, rt, imm};
            CTRL_BEQ:  w_word = {OP_BEQ, rs, rt, imm};
            CTRL_ADDI: w_word = {OP_ADDI, rs, rt, imm};
            CTRL_J:    w_word = {OP_J, target};
            default:   w_legal = 1'b0;
        endcase
    end

`ifdef ENC_CHECK_EN
    logic [8:0] r_cap_ctrl;
    logic       r_chk_err;
    logic [8:0] w_dec_ctrl;

    // Standard main-decoder table applied to the opcode actually being written.
    always_comb begin
        w_dec_ctrl = '0;
        case (r_wdata[31:26])
            OP_R:    w_dec_ctrl = CTRL_R;
            OP_LW:   w_dec_ctrl = CTRL_LW;
            OP_SW:   w_dec_ctrl = CTRL_SW;
            OP_BEQ:  w_dec_ctrl = CTRL_BEQ;
            OP_ADDI: w_dec_ctrl = CTRL_ADDI;
            OP_J:    w_dec_ctrl = CTRL_J;
            default: w_dec_ctrl = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cap_ctrl <= '0;
            r_chk_err  <= 1'b0;
        end else begin
            if (r_state == IDLE && clr) begin
                r_chk_err <= 1'b0;
            end else if (r_state == IDLE && in_valid && w_in_ready && w_legal) begin
                r_cap_ctrl <= w_ctrl;
            end else if (r_state == WRITE && w_dec_ctrl != r_cap_ctrl) begin
                r_chk_err <= 1'b1;
            end
        end
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_we          <= 1'b0;
            r_addr        <= FIRST_ADDR;
            r_wdata       <= '0;
            r_full        <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_count   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr) begin
                        r_addr      <= FIRST_ADDR;
                        r_full      <= 1'b0;
                        r_err_count <= '0;
                    end else if (in_valid && w_in_ready) begin
                        if (w_legal) begin
                            r_wdata <= w_word;
                            r_we    <= 1'b1;
                            r_state <= WRITE;
                        end else begin
                            r_err_illegal <= 1'b1;
                            if (r_err_count != 8'hFF) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                            r_state <= REJECT;
                        end
                    end
                end

                WRITE: begin
                    // Request stays frozen until the memory acknowledges.
                    if (imem_ack) begin
                        r_we    <= 1'b0;
                        r_state <= IDLE;
                        if (r_addr == LAST_ADDR) begin
                            r_full <= 1'b1;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end

                REJECT: begin
                    r_err_illegal <= 1'b0;
                    r_state       <= IDLE;
                end

                default: begin
                    r_we          <= 1'b0;
                    r_err_illegal <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign imem_we     = r_we;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign full        = r_full;
    assign err_illegal = r_err_illegal;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
//
// Self-checking bench for instr_encoder_loader (DEPTH=4, START_ADDR=0).
// Expected (address, word) pairs are pushed to a scoreboard queue when a
// legal bundle is driven and popped when the DUT presents the write.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

    localparam int ADDR_W     = 8;
    localparam int DEPTH      = 4;
    localparam int START_ADDR = 0;

    // Bundle encodings {RegWrite,RegDst,ALUSrc,Branch,MemWrite,MemToReg,Jump,ALUOp}
    localparam logic [8:0] B_R    = 9'b110000010;
    localparam logic [8:0] B_LW   = 9'b101001000;
    localparam logic [8:0] B_SW   = 9'b001010000;
    localparam logic [8:0] B_BEQ  = 9'b000100001;
    localparam logic [8:0] B_ADDI = 9'b101000000;
    localparam logic [8:0] B_J    = 9'b000000100;
    localparam logic [8:0] B_JB   = 9'b000100100;
    localparam logic [8:0] B_ZERO = 9'b000000000;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [8:0]        b_ctrl;
    logic              RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemToReg, Jump;
    logic [1:0]        ALUOp;
    logic [4:0]        rs, rt, rd, shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ack;
    logic              full;
    logic              err_illegal;
    logic [7:0]        err_count;
    logic              chk_err;

    assign {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemToReg, Jump, ALUOp} = b_ctrl;

    instr_encoder_loader #(
        .ADDR_W(ADDR_W),
        .DEPTH(DEPTH),
        .START_ADDR(START_ADDR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .RegWrite(RegWrite),
        .RegDst(RegDst),
        .ALUSrc(ALUSrc),
        .Branch(Branch),
        .MemWrite(MemWrite),
        .MemToReg(MemToReg),
        .Jump(Jump),
        .ALUOp(ALUOp),
        .rs(rs),
        .rt(rt),
        .rd(rd),
        .shamt(shamt),
        .funct(funct),
        .imm(imm),
        .target(target),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .imem_ack(imem_ack),
        .full(full),
        .err_illegal(err_illegal),
        .err_count(err_count),
        .chk_err(chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [39:0]       sb_q[$];
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_full;
    logic [7:0]        exp_err;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Present a bundle and hold it until accepted (bounded). Returns just
    // after the accepting edge with in_valid dropped.
    task automatic drive(input logic [8:0] c, input logic [4:0] a_rs, input logic [4:0] a_rt,
                         input logic [4:0] a_rd, input logic [4:0] a_sh, input logic [5:0] a_fn,
                         input logic [15:0] a_imm, input logic [25:0] a_tgt, output bit ok);
        @(posedge clk); #1;
        b_ctrl = c; rs = a_rs; rt = a_rt; rd = a_rd; shamt = a_sh;
        funct = a_fn; imm = a_imm; target = a_tgt;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic write_word(input logic [8:0] c, input logic [4:0] a_rs, input logic [4:0] a_rt,
                              input logic [4:0] a_rd, input logic [4:0] a_sh, input logic [5:0] a_fn,
                              input logic [15:0] a_imm, input logic [25:0] a_tgt,
                              input logic [31:0] exp_word, input int ack_delay);
        bit          ok;
        logic [39:0] e;
        sb_q.push_back({exp_addr, exp_word});
        drive(c, a_rs, a_rt, a_rd, a_sh, a_fn, a_imm, a_tgt, ok);
        if (!ok) begin
            void'(sb_q.pop_back());
            return;
        end
        @(negedge clk);
        check("we_latency", 32'(imem_we), 32'd1);
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            check("hold_we", 32'(imem_we), 32'd1);
            check("hold_addr", 32'(imem_addr), 32'(sb_q[0][39:32]));
            check("hold_wdata", imem_wdata, sb_q[0][31:0]);
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        e = sb_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e[39:32]));
        check("wr_wdata", imem_wdata, e[31:0]);
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        if (exp_addr == ADDR_W'(START_ADDR + DEPTH - 1)) exp_full = 1'b1;
        else exp_addr = exp_addr + ADDR_W'(1);
        @(negedge clk);
        check("post_we", 32'(imem_we), 32'd0);
        check("post_addr", 32'(imem_addr), 32'(exp_addr));
        check("post_full", 32'(full), 32'(exp_full));
        check("post_ready", 32'(in_ready), 32'(!exp_full));
        check("chk_err", 32'(chk_err), 32'd0);
    endtask

    task automatic reject(input logic [8:0] c);
        bit ok;
        drive(c, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h1234, 26'h0, ok);
        if (!ok) return;
        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        @(negedge clk);
        check("rej_pulse", 32'(err_illegal), 32'd1);
        check("rej_no_we", 32'(imem_we), 32'd0);
        @(negedge clk);
        check("rej_pulse_end", 32'(err_illegal), 32'd0);
        check("rej_count", 32'(err_count), 32'(exp_err));
        check("rej_addr", 32'(imem_addr), 32'(exp_addr));
        check("rej_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic do_clr();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        exp_addr = ADDR_W'(START_ADDR);
        exp_full = 1'b0;
        exp_err  = 8'd0;
        @(negedge clk);
        check("clr_addr", 32'(imem_addr), 32'(exp_addr));
        check("clr_full", 32'(full), 32'd0);
        check("clr_count", 32'(err_count), 32'd0);
        check("clr_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; imem_ack = 1'b0;
        b_ctrl = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0; target = '0;
        exp_addr = ADDR_W'(START_ADDR); exp_full = 1'b0; exp_err = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), START_ADDR);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_illegal", 32'(err_illegal), 32'd0);
        check("rst_count", 32'(err_count), 32'd0);
        check("rst_chk", 32'(chk_err), 32'd0);

        // R-type add $3,$1,$2 with immediate ack; lw with 3-cycle ack stall
        write_word(B_R, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 32'h0022_1820, 0);
        write_word(B_LW, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 32'h8C08_0004, 3);

        // Ack outside WRITE is ignored
        @(posedge clk); #1 imem_ack = 1'b1;
        @(posedge clk); #1 imem_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_addr", 32'(imem_addr), 32'(exp_addr));
        check("stray_ack_we", 32'(imem_we), 32'd0);

        // Illegal bundles
        reject(B_JB);
        reject(B_ZERO);
        check("err_count_2", 32'(err_count), 32'd2);

        // clr and in_valid together: clr wins, bundle not accepted
        @(posedge clk); #1;
        clr = 1'b1; in_valid = 1'b1; b_ctrl = B_R;
        @(negedge clk);
        check("clr_blocks_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        exp_addr = ADDR_W'(START_ADDR); exp_full = 1'b0; exp_err = 8'd0;
        @(negedge clk);
        check("clr_coll_we", 32'(imem_we), 32'd0);
        check("clr_coll_addr", 32'(imem_addr), START_ADDR);
        check("clr_coll_count", 32'(err_count), 32'd0);

        // Fill all DEPTH words
        write_word(B_SW, 5'd29, 5'd9, 5'd0, 5'd0, 6'h0, 16'hFFF8, 26'h0, 32'hAFA9_FFF8, 0);
        write_word(B_BEQ, 5'd8, 5'd9, 5'd0, 5'd0, 6'h0, 16'h0003, 26'h0, 32'h1109_0003, 1);
        write_word(B_ADDI, 5'd0, 5'd10, 5'd0, 5'd0, 6'h0, 16'h0007, 26'h0, 32'h200A_0007, 0);
        write_word(B_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h000_0010, 32'h0800_0010, 2);
        check("full_set", 32'(full), 32'd1);
        check("full_addr_hold", 32'(imem_addr), 32'(DEPTH - 1));

        // No acceptance while full
        @(posedge clk); #1;
        in_valid = 1'b1; b_ctrl = B_SW;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_no_ready", 32'(in_ready), 32'd0);
            check("full_no_we", 32'(imem_we), 32'd0);
        end
        @(posedge clk); #1 in_valid = 1'b0;

        do_clr();

        // Saturating error counter
        for (int i = 0; i < 260; i++) reject(B_JB);
        check("err_sat", 32'(err_count), 32'd255);
        do_clr();

        // Reset in the middle of a pending write
        write_word(B_ADDI, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h8000, 26'h0, 32'h2021_8000, 0);
        drive(B_LW, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0010, 26'h0, ok);
        @(negedge clk);
        check("midwr_we", 32'(imem_we), 32'd1);
        check("midwr_addr", 32'(imem_addr), 32'd1);
        check("midwr_wdata", imem_wdata, 32'h8C43_0010);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_abort_we", 32'(imem_we), 32'd0);
        check("rst_abort_addr", 32'(imem_addr), START_ADDR);
        check("rst_abort_ready", 32'(in_ready), 32'd1);
        check("rst_abort_wdata", imem_wdata, 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
